// File: rtl/seq_delay_checker.sv
// seq_delay_checker: bounded-delay sequence checker for "trig ##DELAY (lhs > rhs)".
//
// Each accepted trig (en && trig) launches an obligation into a DELAY-deep pending
// shift register. DELAY edges later the obligation matures and is judged on the lhs/rhs
// values sampled at that edge, using a signed strict greater-than compare. The result is
// a registered one-cycle pass or fail pulse. Failures feed a saturating counter. The
// cycle index of the first failure is latched.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset; has priority over everything
//   en                allows trig to launch new obligations
//   trig              antecedent of the sequence
//   lhs, rhs          signed consequent operands, sampled at maturity
//   clear             synchronous clear of obligations, results, counter and first-fail
//                     record (cycle_count is kept)
//   pass, fail        one-cycle result pulses, registered
//   fail_count        saturating failure count
//   first_fail_valid  set once a failure has been recorded
//   first_fail_time   cycle index of the first failure
//   cycle_count       free-running cycle index

module seq_delay_checker #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DELAY  = 1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TIME_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    trig,
    input  logic signed [WIDTH-1:0] lhs,
    input  logic signed [WIDTH-1:0] rhs,
    input  logic                    clear,
    output logic                    pass,
    output logic                    fail,
    output logic [CNT_W-1:0]        fail_count,
    output logic                    first_fail_valid,
    output logic [TIME_W-1:0]       first_fail_time,
    output logic [TIME_W-1:0]       cycle_count
);

    if (DELAY == 0 || DELAY > 8) begin : g_bad_delay
        $error("seq_delay_checker: DELAY must be in 1..8");
    end

    logic [DELAY-1:0]  pending_q, pending_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [CNT_W-1:0]  fail_count_q, fail_count_d;
    logic              ffv_q, ffv_d;
    logic [TIME_W-1:0] fft_q, fft_d;
    logic [TIME_W-1:0] cycle_q, cycle_d;
    logic              mature;
    logic              gt;

    always_comb begin
        cycle_d      = cycle_q + TIME_W'(1);
        mature       = pending_q[DELAY-1];
        gt           = lhs > rhs;
        // Bit k holds an obligation launched k+1 edges ago; the top bit matures now.
        pending_d    = pending_q << 1;
        pending_d[0] = en & trig;
        pass_d       = mature & gt;
        fail_d       = mature & ~gt;
        fail_count_d = fail_count_q;
        ffv_d        = ffv_q;
        fft_d        = fft_q;

        if (fail_d) begin
            if (fail_count_q != {CNT_W{1'b1}}) begin
                fail_count_d = fail_count_q + CNT_W'(1);
            end
            if (!ffv_q) begin
                ffv_d = 1'b1;
                fft_d = cycle_q;
            end
        end

        // Clear also cancels any launch and any result that matures on this edge.
        if (clear) begin
            pending_d    = '0;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
            fail_count_d = '0;
            ffv_d        = 1'b0;
            fft_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_count_q <= '0;
            ffv_q        <= 1'b0;
            fft_q        <= '0;
            cycle_q      <= '0;
        end else begin
            pending_q    <= pending_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            fail_count_q <= fail_count_d;
            ffv_q        <= ffv_d;
            fft_q        <= fft_d;
            cycle_q      <= cycle_d;
        end
    end

    assign pass             = pass_q;
    assign fail             = fail_q;
    assign fail_count       = fail_count_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_time  = fft_q;
    assign cycle_count      = cycle_q;

endmodule

// File: doc/seq_delay_checker.md
SEQ_DELAY_CHECKER -- requirements
Module: seq_delay_checker

Interface
REQ-001 Parameter WIDTH, default 32, width of the signed compare operands.
REQ-002 Parameter DELAY, default 1, cycles from antecedent to consequent check; legal range 1..8.
REQ-003 Parameter CNT_W, default 16, width of the saturating fail counter.
REQ-004 Parameter TIME_W, default 32, width of the cycle counter and timestamp.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007 en  input  1  when high, trig may launch new obligations.
REQ-008 trig  input  1  antecedent of sequence "trig ##DELAY (lhs > rhs)".
REQ-009 lhs  input  WIDTH  signed left operand of the consequent.
REQ-010 rhs  input  WIDTH  signed right operand of the consequent.
REQ-011 clear  input  1  synchronous clear of counters, flags and pending obligations.
REQ-012 pass  output  1  one-cycle pulse: an obligation matured with lhs > rhs.
REQ-013 fail  output  1  one-cycle pulse: an obligation matured with lhs <= rhs.
REQ-014 fail_count  output  CNT_W  saturating count of failures.
REQ-015 first_fail_valid  output  1  high once a failure has been recorded.
REQ-016 first_fail_time  output  TIME_W  cycle index of first failure.
REQ-017 cycle_count  output  TIME_W  free-running cycle index.

Function
REQ-018 cycle_count SHALL increment by 1 every edge not in reset, wrapping modulo 2^TIME_W; "cycle n" is the edge at which cycle_count reads n before incrementing.
REQ-019 At edge n, en && trig SHALL launch an obligation into a DELAY-deep shift register of pending bits.
REQ-020 An obligation launched at edge n SHALL mature at edge n+DELAY, evaluated on lhs/rhs sampled at that edge.
REQ-021 Compare SHALL be two's-complement signed, strict greater-than, full WIDTH.
REQ-022 pass/fail SHALL be registered: visible during the cycle after edge n+DELAY, high one cycle; never both high.
REQ-023 Obligations launched on consecutive edges SHALL each mature independently (overlapping, one result per edge max).
REQ-024 en low SHALL block new launches only; obligations already pending SHALL still mature and report.
REQ-025 On fail, fail_count SHALL increment by 1, holding at 2^CNT_W-1 (no wrap).
REQ-026 On first fail while first_fail_valid is low, first_fail_time SHALL capture the maturing edge's cycle index and first_fail_valid SHALL set; later fails SHALL not alter them.
REQ-027 clear at edge n SHALL zero pending obligations, fail_count, first_fail_valid, first_fail_time, pass and fail at edge n; cycle_count SHALL NOT be affected.
REQ-028 clear and a launch at the same edge: clear wins, no obligation launched.
REQ-029 clear and a maturing obligation at the same edge: no pass/fail reported, counters stay zero.
REQ-030 DELAY outside 1..8 SHALL be a elaboration-time error.

Reset
REQ-031 rst_n low at an edge SHALL set cycle_count, fail_count, first_fail_time to 0, first_fail_valid, pass, fail low, and discard all pending obligations.
REQ-032 Reset mid-operation SHALL produce no pass/fail for obligations launched before reset; reporting resumes only for launches after rst_n returns high.
REQ-033 rst_n takes priority over clear and over all launches.

Verification
REQ-034 DELAY=1, trig=en=1 from cycle 0, lhs=n, rhs=2n at cycle n -> fail from cycle 1 onward (lhs=rhs=0 at... 0 unused), fail at cycles 1,2,3..., first_fail_time=1, fail_count=k after k failures.
REQ-035 Same stimulus with lhs=2n+1, rhs=n -> pass every cycle from cycle 1, fail never, first_fail_valid stays 0.
REQ-036 DELAY=3, single trig at cycle 5, lhs=-1, rhs=0 at cycle 8 -> single fail pulse after edge 8, first_fail_time=8; lhs=0x7FFFFFFF, rhs=0x80000000 -> pass (signed).
REQ-037 CNT_W=4, 20 consecutive failures -> fail_count reaches 15 and holds.
REQ-038 DELAY=2, trig at cycles 10,11; clear at cycle 12 -> no result for cycle-10 launch, none for cycle-11 launch, counters zero, cycle_count unaffected.
REQ-039 DELAY=4, trig at cycle 3, rst_n low at cycle 5 for one cycle -> no pass/fail at cycle 7; cycle_count restarts from 0.
